// File: rtl/forth_pkg.sv
// Shared encodings for the Forth execute stage: mux selects, ALU ops and
// register function codes decoded from the control word.
package forth_pkg;
  localparam int DATA_W_DEF = 3;
  localparam int ADDR_W_DEF = 12;

  localparam logic [1:0] ASEL_I = 2'b00;
  localparam logic [1:0] ASEL_J = 2'b01;
  localparam logic [1:0] ASEL_S = 2'b10;
  localparam logic [1:0] ASEL_H = 2'b11;

  localparam logic [1:0] ALU_SHL  = 2'b00;
  localparam logic [1:0] ALU_SHL1 = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;
  localparam logic [1:0] ALU_SUB  = 2'b11;

  localparam logic [1:0] I_HOLD = 2'b00;
  localparam logic [1:0] I_INC  = 2'b01;
  localparam logic [1:0] I_LDJ  = 2'b10;

  localparam logic [2:0] J_HOLD = 3'b000;
  localparam logic [2:0] J_INC  = 3'b001;
  localparam logic [2:0] J_LDA  = 3'b010;

  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_INC  = 2'b01;
  localparam logic [1:0] S_DEC  = 2'b10;
  localparam logic [1:0] S_LDJ  = 2'b11;

  localparam logic [1:0] F_HOLD = 2'b00;
  localparam logic [1:0] F_ALU  = 2'b01;
  localparam logic [1:0] F_SET  = 2'b10;
  localparam logic [1:0] F_CLR  = 2'b11;
endpackage

// File: rtl/forth_alu.sv
// Combinational ALU: shift-in of a bit into T, RAM pass-through, or RAM minus T
// with borrow as the flag; otherwise the flag is a zero test.
module forth_alu
  import forth_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        alu_f,
  input  logic [DATA_W-1:0] t,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] alu_out,
  output logic              f_in
);
  always_comb begin
    alu_out = '0;
    case (alu_f)
      ALU_SHL:  alu_out = {t[DATA_W-2:0], 1'b0};
      ALU_SHL1: alu_out = {t[DATA_W-2:0], 1'b1};
      ALU_PASS: alu_out = mem_rdata;
      default:  alu_out = mem_rdata - t;
    endcase
    f_in = (alu_f == ALU_SUB) ? (mem_rdata < t) : (alu_out == '0);
  end
endmodule

// File: rtl/forth_datapath.sv
// Execute stage of the 3-bit Forth core: architectural registers, RAM port and
// decoder feedback. Define STACK_GUARD_EN to trap S over/underflow in stk_err.
module forth_datapath
  import forth_pkg::*;
#(
  parameter int                DATA_W     = DATA_W_DEF,
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter logic [ADDR_W-1:0] STACK_BASE = 12'hFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [1:0]        a_sel,
  input  logic              b_sel,
  input  logic              c_sel,
  input  logic              d_sel,
  input  logic [1:0]        alu_f,
  input  logic [1:0]        i_f,
  input  logic [2:0]        j_f,
  input  logic [1:0]        s_f,
  input  logic [1:0]        f_f,
  input  logic              t_f,
  input  logic              h_f,
  input  logic              r_f,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] reg_t,
  output logic              reg_p,
  output logic              reg_f,
  output logic              stk_err
);
  localparam int NCHUNK = ADDR_W / DATA_W;

  logic [ADDR_W-1:0] i_q, j_q, s_q, h_q;
  logic [DATA_W-1:0] t_q;
  logic              f_q, p_q;

  logic [ADDR_W-1:0] mux_a, i_d, j_d, s_d;
  logic [DATA_W-1:0] mux_b, mux_c, mux_d, alu_out, j_chunk, t_d;
  logic              f_in, f_d, s_ovf;
  logic [NCHUNK-1:0][DATA_W-1:0] j_parts, j_load;

  forth_alu #(.DATA_W(DATA_W)) u_alu (
    .alu_f     (alu_f),
    .t         (t_q),
    .mem_rdata (mem_rdata),
    .alu_out   (alu_out),
    .f_in      (f_in)
  );

  always_comb begin
    mux_a = i_q;
    case (a_sel)
      ASEL_I:  mux_a = i_q;
      ASEL_J:  mux_a = j_q;
      ASEL_S:  mux_a = s_q;
      default: mux_a = h_q;
    endcase
  end

  // J viewed as NCHUNK words of DATA_W; chunk kk comes from j_f[1:0].
  assign j_parts = j_q;
  assign j_chunk = j_parts[j_f[1:0]];
  assign mux_b   = b_sel ? mem_rdata : mux_a[DATA_W-1:0];
  assign mux_d   = d_sel ? mem_rdata : alu_out;
  assign mux_c   = c_sel ? j_chunk : mux_d;

  always_comb begin
    j_load            = j_parts;
    j_load[j_f[1:0]]  = mux_b;
  end

  always_comb begin
    i_d = i_q;
    case (i_f)
      I_INC:   i_d = i_q + ADDR_W'(1);
      I_LDJ:   i_d = j_q;
      default: i_d = i_q;
    endcase

    j_d = j_q;
    if (j_f[2])             j_d = j_load;
    else if (j_f == J_INC)  j_d = j_q + ADDR_W'(1);
    else if (j_f == J_LDA)  j_d = mux_a;

`ifdef STACK_GUARD_EN
    s_ovf = ((s_f == S_INC) && (s_q == '1)) || ((s_f == S_DEC) && (s_q == '0));
`else
    s_ovf = 1'b0;
`endif
    s_d = s_q;
    if (!s_ovf) begin
      case (s_f)
        S_INC:   s_d = s_q + ADDR_W'(1);
        S_DEC:   s_d = s_q - ADDR_W'(1);
        S_LDJ:   s_d = j_q;
        default: s_d = s_q;
      endcase
    end

    f_d = f_q;
    case (f_f)
      F_ALU:   f_d = f_in;
      F_SET:   f_d = 1'b1;
      F_CLR:   f_d = 1'b0;
      default: f_d = f_q;
    endcase

    t_d = t_f ? mux_c : t_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= RESET_VEC;
      j_q <= '0;
      s_q <= STACK_BASE;
      h_q <= '0;
      t_q <= '0;
      f_q <= 1'b0;
      p_q <= 1'b0;
    end else if (!stall) begin
      i_q <= i_d;
      j_q <= j_d;
      s_q <= s_d;
      if (h_f) h_q <= i_q;
      t_q <= t_d;
      f_q <= f_d;
      p_q <= ~p_q;
    end
  end

`ifdef STACK_GUARD_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)                 err_q <= 1'b0;
    else if (!stall && s_ovf) err_q <= 1'b1;
  end
  assign stk_err = err_q;
`else
  assign stk_err = 1'b0;
`endif

  assign mem_addr  = mux_a;
  assign mem_wdata = t_q;
  assign mem_we    = r_f & ~stall;
  assign reg_t     = t_q;
  assign reg_p     = p_q;
  assign reg_f     = f_q;
endmodule

// File: tb/tb_forth_datapath.sv
// Randomized bench for forth_datapath against an integer-arithmetic model of the
// architectural registers; follows STACK_GUARD_EN like the design.
module tb_forth_datapath;
  localparam int DW = 3;
  localparam int AW = 12;
  localparam int AMOD = 4096;
  localparam int DMOD = 8;

  logic          clk = 1'b0;
  logic          rst, stall, b_sel, c_sel, d_sel, t_f, h_f, r_f;
  logic [1:0]    a_sel, alu_f, i_f, s_f, f_f;
  logic [2:0]    j_f;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata, mem_wdata, reg_t;
  logic          mem_we, reg_p, reg_f, stk_err;

  int n_chk = 0;
  int n_pass = 0;
  int mI, mJ, mS, mH, mT, mF, mP, mE;

  forth_datapath dut (
    .clk(clk), .rst(rst), .stall(stall), .a_sel(a_sel), .b_sel(b_sel),
    .c_sel(c_sel), .d_sel(d_sel), .alu_f(alu_f), .i_f(i_f), .j_f(j_f),
    .s_f(s_f), .f_f(f_f), .t_f(t_f), .h_f(h_f), .r_f(r_f),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .reg_t(reg_t), .reg_p(reg_p), .reg_f(reg_f),
    .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int amux(input int sel);
    case (sel)
      0: return mI;
      1: return mJ;
      2: return mS;
      default: return mH;
    endcase
  endfunction

  function automatic int pow8(input int k);
    int r = 1;
    for (int n = 0; n < k; n++) r = r * DMOD;
    return r;
  endfunction

  task automatic clr();
    rst = 0; stall = 0; a_sel = 0; b_sel = 0; c_sel = 0; d_sel = 0;
    alu_f = 0; i_f = 0; j_f = 0; s_f = 0; f_f = 0; t_f = 0; h_f = 0; r_f = 0;
    mem_rdata = 0;
  endtask

  // One clock: check combinational outputs, clock, advance model, check registers.
  task automatic cyc();
    int a, b, alu, fin, d, k, w, jc, c;
    int nI, nJ, nS, nH, nT, nF, nE;
    #1;
    a = amux(a_sel);
    chk("mem_addr", mem_addr, a);
    chk("mem_we", mem_we, (r_f && !stall) ? 1 : 0);
    chk("mem_wdata", mem_wdata, mT);

    b = b_sel ? int'(mem_rdata) : a % DMOD;
    case (alu_f)
      0: alu = (mT * 2) % DMOD;
      1: alu = (mT * 2 + 1) % DMOD;
      2: alu = mem_rdata;
      default: alu = (int'(mem_rdata) - mT + DMOD) % DMOD;
    endcase
    fin = (alu_f == 3) ? (int'(mem_rdata) < mT) : (alu == 0);
    d = d_sel ? int'(mem_rdata) : alu;
    k = j_f % 4;
    w = pow8(k);
    jc = (mJ / w) % DMOD;
    c = c_sel ? jc : d;

    nI = mI; nJ = mJ; nS = mS; nH = mH; nT = mT; nF = mF; nE = mE;
    if (i_f == 1) nI = (mI + 1) % AMOD;
    else if (i_f == 2) nI = mJ;
    if (j_f >= 4) nJ = mJ - jc * w + b * w;
    else if (j_f == 1) nJ = (mJ + 1) % AMOD;
    else if (j_f == 2) nJ = a;
`ifdef STACK_GUARD_EN
    if (s_f == 1 && mS == AMOD - 1) nE = 1;
    else if (s_f == 2 && mS == 0) nE = 1;
    else if (s_f == 1) nS = mS + 1;
    else if (s_f == 2) nS = mS - 1;
    else if (s_f == 3) nS = mJ;
`else
    if (s_f == 1) nS = (mS + 1) % AMOD;
    else if (s_f == 2) nS = (mS + AMOD - 1) % AMOD;
    else if (s_f == 3) nS = mJ;
`endif
    if (f_f == 1) nF = fin;
    else if (f_f == 2) nF = 1;
    else if (f_f == 3) nF = 0;
    if (t_f) nT = c;
    if (h_f) nH = mI;

    @(posedge clk);
    #1;
    if (rst) begin
      mI = 0; mJ = 0; mS = AMOD - 1; mH = 0; mT = 0; mF = 0; mP = 0; mE = 0;
    end else if (!stall) begin
      mI = nI; mJ = nJ; mS = nS; mH = nH; mT = nT; mF = nF; mE = nE; mP = 1 - mP;
    end
    chk("reg_t", reg_t, mT);
    chk("reg_p", reg_p, mP);
    chk("reg_f", reg_f, mF);
    chk("stk_err", stk_err, mE);
  endtask

  // Observe I/J/S/H through mem_addr while stalled; no clock edge is crossed.
  task automatic probe();
    stall = 1;
    for (int sel = 0; sel < 4; sel++) begin
      a_sel = sel[1:0];
      #1;
      chk("probe", mem_addr, amux(sel));
    end
    stall = 0;
  endtask

  task automatic set_j(input int val);
    for (int k = 0; k < 4; k++) begin
      clr();
      j_f = 3'(4 + k);
      b_sel = 1;
      mem_rdata = DW'((val / pow8(k)) % DMOD);
      cyc();
    end
  endtask

  task automatic set_t(input int val);
    clr();
    alu_f = 2'b10; t_f = 1; mem_rdata = DW'(val);
    cyc();
  endtask

  initial begin
    mI = 0; mJ = 0; mS = AMOD - 1; mH = 0; mT = 0; mF = 0; mP = 0; mE = 0;
    clr();
    // reset held two cycles, then P toggles
    rst = 1; r_f = 1; i_f = 1;
    cyc(); cyc();
    chk("rst_t", reg_t, 0);
    chk("rst_p", reg_p, 0);
    probe();
    a_sel = 2'b10; stall = 1; #1;
    chk("rst_s", mem_addr, 12'hFFF);
    clr();
    for (int n = 0; n < 4; n++) begin
      cyc();
      chk("p_toggle", reg_p, (n % 2 == 0) ? 1 : 0);
    end

    // MIN
    set_j(12'h010);
    clr(); s_f = 2'b11; cyc();
    set_t(7);
    clr(); mem_rdata = 3'd5; alu_f = 2'b11; s_f = 2'b01; t_f = 1; f_f = 2'b01;
    cyc();
    chk("min_t", reg_t, 6);
    chk("min_f", reg_f, 1);
    stall = 1; a_sel = 2'b10; #1;
    chk("min_s", mem_addr, 12'h011);

    // J chunk load and read-back into T
    set_j(0);
    clr(); j_f = 3'b110; b_sel = 1; mem_rdata = 3'd5; cyc();
    stall = 1; a_sel = 2'b01; #1;
    chk("chunk_j", mem_addr, 12'h140);
    clr(); c_sel = 1; j_f = 3'b110; t_f = 1; b_sel = 1; mem_rdata = 3'd5; cyc();
    chk("chunk_t", reg_t, 5);

    // CAL swap
    set_j(12'h020);
    clr(); i_f = 2'b10; cyc();
    set_j(12'h300);
    clr(); a_sel = 2'b00; i_f = 2'b10; j_f = 3'b010; cyc();
    stall = 1; a_sel = 2'b00; #1;
    chk("swap_i", mem_addr, 12'h300);
    a_sel = 2'b01; #1;
    chk("swap_j", mem_addr, 12'h020);

    // DBL write with S underflow
    set_j(0);
    clr(); s_f = 2'b11; cyc();
    set_t(3);
    clr(); a_sel = 2'b10; r_f = 1; s_f = 2'b10; #1;
    chk("dbl_we", mem_we, 1);
    chk("dbl_addr", mem_addr, 0);
    chk("dbl_wdata", mem_wdata, 3);
    cyc();
    stall = 1; a_sel = 2'b10; #1;
`ifdef STACK_GUARD_EN
    chk("dbl_s", mem_addr, 0);
    chk("dbl_err", stk_err, 1);
`else
    chk("dbl_s", mem_addr, 12'hFFF);
`endif

    // stall freezes state, then reset wins over stall
    clr(); set_j(12'h555); clr(); i_f = 2'b10; cyc();
    clr(); stall = 1; i_f = 2'b01; r_f = 1;
    for (int n = 0; n < 3; n++) begin
      cyc();
      chk("stall_we", mem_we, 0);
    end
    probe();
    clr(); stall = 1; rst = 1; cyc();
    probe();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 40) == 0);
      stall     = ($urandom_range(0, 7) == 0);
      a_sel     = 2'($urandom);
      b_sel     = 1'($urandom);
      c_sel     = 1'($urandom);
      d_sel     = 1'($urandom);
      alu_f     = 2'($urandom);
      i_f       = 2'($urandom);
      j_f       = 3'($urandom);
      s_f       = 2'($urandom);
      f_f       = 2'($urandom);
      t_f       = 1'($urandom);
      h_f       = 1'($urandom);
      r_f       = 1'($urandom);
      mem_rdata = 3'($urandom);
      cyc();
      if (n % 16 == 0) probe();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/forth_datapath.md
Name: forth_datapath

Overview:
- Execute stage of the 3-bit Forth core, directly downstream of the instruction decoder.
- Consumes the decoder's registered control word (A/B/C/D selects, ALU_F, I_F, J_F, S_F, F_F, T_F, H_F, R_F).
- Owns the architectural registers I, J, S, H, T, F and the phase bit P, and drives the single-port RAM interface.
- Feeds T, P and F back to the decoder as RegT, regP and regF.

Parameters:
- DATA_W, 3, word width (T, RAM data, J chunk).
- ADDR_W, 12, address width (I, J, S, H); must equal 4*DATA_W.
- RESET_VEC, 0, reset value of I.
- STACK_BASE, 12'hFFF, reset value of S.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  when 1, all registers hold and mem_we is forced to 0.
- a_sel  in  2  muxA: 00 I, 01 J, 10 S, 11 H.
- b_sel  in  1  muxB: 0 muxA[DATA_W-1:0], 1 mem_rdata.
- c_sel  in  1  muxC: 0 muxD, 1 J chunk selected by j_f[1:0].
- d_sel  in  1  muxD: 0 alu_out, 1 mem_rdata.
- alu_f  in  2  00 T<<1, 01 (T<<1)|1, 10 mem_rdata, 11 mem_rdata-T.
- i_f  in  2  00 hold, 01 I+1, 10 I<=J, 11 hold.
- j_f  in  3  000 hold, 001 J+1, 010 J<=muxA, 011 hold, 1kk chunk kk of J<=muxB.
- s_f  in  2  00 hold, 01 S+1, 10 S-1, 11 S<=J.
- f_f  in  2  00 hold, 01 F<=f_in, 10 F<=1, 11 F<=0.
- t_f  in  1  1: T<=muxC.
- h_f  in  1  1: H<=I.
- r_f  in  1  1: write T to RAM[muxA].
- mem_addr  out  ADDR_W  muxA, combinational.
- mem_rdata  in  DATA_W  RAM read data (valD), combinational read.
- mem_wdata  out  DATA_W  = T.
- mem_we  out  1  = r_f & ~stall.
- reg_t  out  DATA_W  T register (decoder RegT).
- reg_p  out  1  phase bit (decoder regP).
- reg_f  out  1  flag register (decoder regF).
- stk_err  out  1  stack guard error (only with STACK_GUARD_EN; tied 0 otherwise).

Behaviour:
- Reset (rst=1 at an edge; overrides stall):
  - I=RESET_VEC, J=0, S=STACK_BASE, H=0, T=0, F=0, P=0, stk_err=0.
  - Reset mid-operation discards the in-flight control word. mem_we still follows r_f combinationally during the reset cycle.
- Phase: P toggles every non-stalled cycle; P=0 is fetch, P=1 is execute.
- Single-cycle execute: every non-stalled edge applies the current control word simultaneously, using pre-edge values.
  - Swaps are exact: i_f=10 with j_f=010, a_sel=00 exchanges I and J.
- Chunk index: chunk kk = J[(kk+1)*DATA_W-1 : kk*DATA_W]. Loading a chunk leaves the other chunks unchanged.
- ALU arithmetic: DATA_W-bit, wraps modulo 2^DATA_W. The shift drops the MSB.
- f_in:
  - alu_f=11: borrow (mem_rdata < T).
  - Otherwise: (alu_out == 0).
- Counter wrap: I, J, S wrap modulo 2^ADDR_W. S-1 at 0 gives all-ones; S+1 at all-ones gives 0.
- Conflicts: reserved encodings (i_f=11, j_f=011) hold. h_f and i_f together: H takes the old I.
- Write: mem_we asserts in the same cycle as r_f. The RAM captures on the same edge, and T is unaffected.
- stall: freezes every register including P. mem_addr still tracks muxA.

Optional Feature:
- STACK_GUARD_EN.
- Defined:
  - An S+1 at all-ones or an S-1 at 0 does not update S.
  - Instead it sets sticky stk_err=1.
  - stk_err clears only on rst.
- Undefined: S wraps silently and stk_err is tied 0.

Decomposition:
- Package forth_pkg holds:
  - select encodings: ASEL_I/J/S/H, ALU_SHL/SHL1/PASS/SUB;
  - I_/J_/S_/F_ function codes;
  - DATA_W/ADDR_W defaults.
- Sub-module forth_alu: combinational; (alu_f, T, mem_rdata) -> (alu_out, f_in).

Test Plan:
- Reset: hold rst 2 cycles -> I=0, S=12'hFFF, T=0, F=0, P=0. P then toggles 0,1,0,1.
- MIN: S=12'h010, mem_rdata=3'd5, T=3'd7, alu_f=11, s_f=01, t_f=1, f_f=01 -> T=3'd6, F=1, S=12'h011.
- J chunk load: J=12'h000, j_f=110, b_sel=1, mem_rdata=3'd5 -> J=12'h140. Then c_sel=1, j_f=110, t_f=1 -> T=3'd5.
- CAL swap: I=12'h020, J=12'h300, a_sel=00, i_f=10, j_f=010 -> I=12'h300, J=12'h020.
- DBL write plus wrap: S=0, T=3'd3, a_sel=10, r_f=1, s_f=10:
  - mem_we=1, mem_addr=0, mem_wdata=3.
  - Next S=12'hFFF; with STACK_GUARD_EN, S stays 0 and stk_err=1.
- Stall: stall=1 with i_f=01, r_f=1 for 3 cycles -> I, P unchanged and mem_we=0. Then rst during stall -> reset values.
